// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle controller.
//   - opcode codes (bits [3:0] of the instruction opcode field)
//   - FSM state encoding (3-bit; the IRQ code is used only when CTRL_IRQ_EN is defined)
//   - ALU mode encodings and the opcode -> mode helper
package ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_LOAD  = 4'd5;
  localparam logic [3:0] OP_STORE = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd7;
  localparam logic [3:0] OP_BEQZ  = 4'd8;
  localparam logic [3:0] OP_HLT   = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_IRQ    = 3'd7
  } state_t;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_AND = 2'd2;
  localparam logic [1:0] MODE_OR  = 2'd3;

  // ALU mode for a register-register opcode; anything else adds
  // (LOAD/STORE use ADD to form the address).
  function automatic logic [1:0] alu_mode(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_mode = MODE_SUB;
      OP_AND:  alu_mode = MODE_AND;
      OP_OR:   alu_mode = MODE_OR;
      default: alu_mode = MODE_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode classifier.
// Ports:
//   op          in  OPW  opcode to classify
//   is_alu      out 1    ADD/SUB/AND/OR
//   is_ld       out 1    LOAD
//   is_st       out 1    STORE
//   is_jmp      out 1    JMP
//   is_beqz     out 1    BEQZ
//   is_halt     out 1    HLT
//   is_illegal  out 1    undefined code or any nonzero bit above [3:0]
// NOP decodes with every flag low.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] op,
  output logic           is_alu,
  output logic           is_ld,
  output logic           is_st,
  output logic           is_jmp,
  output logic           is_beqz,
  output logic           is_halt,
  output logic           is_illegal
);

  logic       hi_set;
  logic [3:0] lo;

  generate
    if (OPW > 4) begin : g_hi
      assign hi_set = |op[OPW-1:4];
    end else begin : g_nohi
      assign hi_set = 1'b0;
    end
  endgenerate

  assign lo = op[3:0];

  always_comb begin
    is_alu     = 1'b0;
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_jmp     = 1'b0;
    is_beqz    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (hi_set) begin
      is_illegal = 1'b1;
    end else begin
      case (lo)
        OP_NOP:                        ;
        OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu  = 1'b1;
        OP_LOAD:                       is_ld   = 1'b1;
        OP_STORE:                      is_st   = 1'b1;
        OP_JMP:                        is_jmp  = 1'b1;
        OP_BEQZ:                       is_beqz = 1'b1;
        OP_HLT:                        is_halt = 1'b1;
        default:                       is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/controller_mc.sv
// controller_mc: multi-cycle CPU controller (FETCH/DECODE/EXEC/MEM/WB)
// with memory-ready wait states, branch-on-zero, halt and illegal-opcode flag.
// Optional feature macro: CTRL_IRQ_EN (adds irq/irq_ack and a one-cycle IRQ state).
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   en                       run enable, sampled only at instruction boundaries
//   opcode [OPW]             opcode from IR, sampled in DECODE
//   zero                     ALU zero flag (BEQZ)
//   mem_ready                memory access completes this cycle
//   loadA/B/C/IR/PC, incPC   datapath register strobes
//   mode [MODEW]             ALU op (0 ADD, 1 SUB, 2 AND, 3 OR)
//   we_DM                    data memory write enable
//   selA, selB               A source (1 = memory), ALU B source (1 = immediate)
//   halted, illegal          in HALT / undefined opcode seen in DECODE
//   irq, irq_ack             interrupt request/acknowledge (CTRL_IRQ_EN only)
module controller_mc
  import ctrl_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int MODEW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OPW-1:0]   opcode,
  input  logic             zero,
  input  logic             mem_ready,
`ifdef CTRL_IRQ_EN
  input  logic             irq,
  output logic             irq_ack,
`endif
  output logic             loadA,
  output logic             loadB,
  output logic             loadC,
  output logic             loadIR,
  output logic             loadPC,
  output logic             incPC,
  output logic [MODEW-1:0] mode,
  output logic             we_DM,
  output logic             selA,
  output logic             selB,
  output logic             halted,
  output logic             illegal
);

  state_t         state, nxt, boundary;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] dec_op;
  logic is_alu, is_ld, is_st, is_jmp, is_beqz, is_halt, is_illegal;

  // DECODE classifies the live opcode; later states use the latched copy.
  assign dec_op = (state == S_DECODE) ? opcode : op_q;

  ctrl_decode #(.OPW(OPW)) u_decode (
    .op         (dec_op),
    .is_alu     (is_alu),
    .is_ld      (is_ld),
    .is_st      (is_st),
    .is_jmp     (is_jmp),
    .is_beqz    (is_beqz),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // Where an instruction goes once it is finished.
  always_comb begin
    boundary = en ? S_FETCH : S_IDLE;
`ifdef CTRL_IRQ_EN
    if (en && irq) boundary = S_IRQ;
`endif
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = en ? S_FETCH : S_IDLE;
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_halt)                                    nxt = S_HALT;
        else if (is_alu || is_ld || is_st || is_jmp || is_beqz) nxt = S_EXEC;
        else                                            nxt = boundary;
      end
      S_EXEC: begin
        if (is_alu)              nxt = S_WB;
        else if (is_ld || is_st) nxt = S_MEM;
        else                     nxt = boundary;
      end
      S_MEM:    if (mem_ready) nxt = is_ld ? S_WB : boundary;
      S_WB:     nxt = boundary;
      S_HALT:   nxt = S_HALT;
`ifdef CTRL_IRQ_EN
      S_IRQ:    nxt = S_FETCH;
`endif
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  // Strobes are decoded from the current state; rst gates them all so an
  // abandoned instruction emits nothing while reset is held.
  always_comb begin
    loadA   = 1'b0;
    loadB   = 1'b0;
    loadC   = 1'b0;
    loadIR  = 1'b0;
    loadPC  = 1'b0;
    incPC   = 1'b0;
    mode    = '0;
    we_DM   = 1'b0;
    selA    = 1'b0;
    selB    = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;
`ifdef CTRL_IRQ_EN
    irq_ack = 1'b0;
`endif
    if (!rst) begin
      case (state)
        S_FETCH: begin
          loadIR = mem_ready;
          incPC  = mem_ready;
        end
        S_DECODE: begin
          loadA   = 1'b1;
          loadB   = 1'b1;
          illegal = is_illegal;
        end
        S_EXEC: begin
          if (is_alu) begin
            mode  = MODEW'(alu_mode(op_q[3:0]));
            loadC = 1'b1;
          end else if (is_ld || is_st) begin
            mode  = MODEW'(MODE_ADD);
            selB  = 1'b1;
            loadC = 1'b1;
          end else if (is_jmp) begin
            loadPC = 1'b1;
          end else if (is_beqz) begin
            loadPC = zero;
          end
        end
        S_MEM:  we_DM = is_st;
        S_WB: begin
          loadA = 1'b1;
          selA  = is_ld;
        end
        S_HALT: halted = 1'b1;
`ifdef CTRL_IRQ_EN
        S_IRQ: begin
          irq_ack = 1'b1;
          loadPC  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_mc.sv
// Directed-vector bench for controller_mc (default build, OPW=4, MODEW=2).
module tb_controller_mc;

  logic       clk = 1'b0;
  logic       rst, en, zero, mem_ready;
  logic [3:0] opcode;
  logic       loadA, loadB, loadC, loadIR, loadPC, incPC, we_DM, selA, selB, halted, illegal;
  logic [1:0] mode;
`ifdef CTRL_IRQ_EN
  logic       irq_ack;
`endif

  int vectors = 0;
  int errors  = 0;

  controller_mc #(.OPW(4), .MODEW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
`ifdef CTRL_IRQ_EN
    .irq       (1'b0),
    .irq_ack   (irq_ack),
`endif
    .loadA     (loadA),
    .loadB     (loadB),
    .loadC     (loadC),
    .loadIR    (loadIR),
    .loadPC    (loadPC),
    .incPC     (incPC),
    .mode      (mode),
    .we_DM     (we_DM),
    .selA      (selA),
    .selB      (selB),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Packed view of every output: {A,B,C,IR,PC,INC,WE,SA,SB,HALT,ILL,mode[1:0]}
  logic [12:0] outs;
  assign outs = {loadA, loadB, loadC, loadIR, loadPC, incPC, we_DM, selA, selB,
                 halted, illegal, mode};

  localparam logic [12:0] NONE = 13'h0000;
  localparam logic [12:0] LA   = 13'h1000;
  localparam logic [12:0] LB   = 13'h0800;
  localparam logic [12:0] LC   = 13'h0400;
  localparam logic [12:0] LIR  = 13'h0200;
  localparam logic [12:0] LPC  = 13'h0100;
  localparam logic [12:0] INC  = 13'h0080;
  localparam logic [12:0] WE   = 13'h0040;
  localparam logic [12:0] SA   = 13'h0020;
  localparam logic [12:0] SB   = 13'h0010;
  localparam logic [12:0] HLT  = 13'h0008;
  localparam logic [12:0] ILL  = 13'h0004;
  localparam logic [12:0] M1   = 13'h0001;
  localparam logic [12:0] M2   = 13'h0002;
  localparam logic [12:0] M3   = 13'h0003;
  localparam logic [12:0] FT   = LIR | INC;
  localparam logic [12:0] DC   = LA | LB;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mem_ready = 1'b1; opcode = 4'd1; zero = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (outs !== NONE) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h, expected %h", i, outs, NONE);
      end
      if (i < 2) cyc();
    end
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (outs !== NONE) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h, expected %h", i, outs, NONE);
      end
      cyc();
    end
    en = 1'b1;
    cyc();
  endtask

  task automatic test_add();
    logic [12:0] exp [5];
    exp = '{FT, DC, LC, LA, FT};
    opcode = 4'd1; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL add[%0d]: got %h, expected %h", i, outs, exp[i]);
      end
      if (i < 4) cyc();
    end
  endtask

  task automatic test_alu_modes();
    logic [12:0] exp [9];
    logic [3:0]  ops [9];
    exp = '{FT, DC, LC | M2, LA, FT, DC, LC | M3, LA, FT};
    ops = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      opcode = ops[i];
      #1;
      vectors++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL alu_mode[%0d]: got %h, expected %h", i, outs, exp[i]);
      end
      if (i < 8) cyc();
    end
  endtask

  task automatic test_nop_fetch_wait();
    logic [12:0] exp [4];
    logic        mr  [4];
    exp = '{NONE, FT, DC, FT};
    mr  = '{1'b0, 1'b1, 1'b1, 1'b1};
    opcode = 4'd0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i];
      #1;
      vectors++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL nop_wait[%0d]: got %h, expected %h", i, outs, exp[i]);
      end
      if (i < 3) cyc();
    end
  endtask

  task automatic test_load_wait();
    logic [12:0] exp [8];
    logic        mr  [8];
    exp = '{FT, DC, LC | SB, NONE, NONE, NONE, LA | SA, FT};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    opcode = 4'd5;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #1;
      vectors++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL load[%0d]: got %h, expected %h", i, outs, exp[i]);
      end
      if (i < 7) cyc();
    end
  endtask

  task automatic test_store();
    logic [12:0] exp [6];
    logic        mr  [6];
    exp = '{FT, DC, LC | SB, WE, WE, FT};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    opcode = 4'd6;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i];
      #1;
      vectors++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL store[%0d]: got %h, expected %h", i, outs, exp[i]);
      end
      if (i < 5) cyc();
    end
  endtask

  task automatic test_branch();
    logic [12:0] exp [10];
    logic [3:0]  ops [10];
    logic        zf  [10];
    exp = '{FT, DC, LPC, FT, DC, NONE, FT, DC, LPC, FT};
    ops = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd7, 4'd7, 4'd7, 4'd7};
    zf  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      opcode = ops[i];
      zero   = zf[i];
      #1;
      vectors++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL branch[%0d]: got %h, expected %h", i, outs, exp[i]);
      end
      if (i < 9) cyc();
    end
  endtask

  task automatic test_illegal();
    logic [12:0] exp [3];
    exp = '{FT, DC | ILL, FT};
    opcode = 4'd9; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL illegal[%0d]: got %h, expected %h", i, outs, exp[i]);
      end
      if (i < 2) cyc();
    end
  endtask

  task automatic test_en_drop();
    logic [12:0] exp [7];
    logic        ens [7];
    exp = '{FT, DC, LC | M1, LA, NONE, NONE, FT};
    ens = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 4'd2; mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      en = ens[i];
      #1;
      vectors++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL en_drop[%0d]: got %h, expected %h", i, outs, exp[i]);
      end
      if (i < 6) cyc();
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [12:0] exp [8];
    logic        rs  [8];
    logic        ens [8];
    logic        mr  [8];
    // STORE stalls in MEM, then reset lands: strobes vanish and the
    // controller stays idle until en returns.
    exp = '{FT, DC, LC | SB, WE, NONE, NONE, NONE, FT};
    rs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ens = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = 4'd6;
    for (int i = 0; i < 8; i++) begin
      rst = rs[i]; en = ens[i]; mem_ready = mr[i];
      #1;
      vectors++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL rst_mid_mem[%0d]: got %h, expected %h", i, outs, exp[i]);
      end
      if (i < 7) cyc();
    end
  endtask

  task automatic test_halt();
    opcode = 4'd15; mem_ready = 1'b1; en = 1'b1;
    #1;
    vectors++;
    if (outs !== FT) begin
      errors++;
      $display("FAIL halt_fetch: got %h, expected %h", outs, FT);
    end
    cyc();
    vectors++;
    if (outs !== DC) begin
      errors++;
      $display("FAIL halt_decode: got %h, expected %h", outs, DC);
    end
    cyc();
    for (int i = 0; i < 10; i++) begin
      en = i[0];
      opcode = 4'd1;
      #1;
      vectors++;
      if (outs !== HLT) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got %h, expected %h", i, outs, HLT);
      end
      cyc();
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (outs !== NONE) begin
      errors++;
      $display("FAIL halt_rst: got %h, expected %h", outs, NONE);
    end
    cyc();
    rst = 1'b0; en = 1'b0;
    #1;
    vectors++;
    if (outs !== NONE) begin
      errors++;
      $display("FAIL halt_idle: got %h, expected %h", outs, NONE);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_modes();
    test_nop_fetch_wait();
    test_load_wait();
    test_store();
    test_branch();
    test_illegal();
    test_en_drop();
    test_reset_mid_mem();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "time limit");
  end

endmodule
